// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (count byte N, then N little-endian
// 32-bit words) over a valid/ready handshake and writes the words to the
// instruction memory at addresses 0..N-1. cpu_hold is high for the whole
// session so fetch never sees a half-written program.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// XOR checksum byte covering the count byte and every data byte.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE} state_t;
`endif

    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] last_addr;   // N-1, address of the final word
    logic              xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer = rx_valid & rx_ready;

    // Session FSM; every output is registered and set alongside the next state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            byte_idx   <= '0;
            last_addr  <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LEN;
                        rx_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        load_err   <= 1'b0;
                        imem_waddr <= '0;
                        byte_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        last_addr <= ADDR_W'(rx_data - 8'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum      <= rx_data;
`endif
                        // Bounding N here is what keeps the address from wrapping.
                        if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
                            load_err  <= 1'b1;
                            rx_ready  <= 1'b0;
                            load_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            rx_ready <= 1'b0;
                            imem_we  <= 1'b1;
                            state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_waddr == last_addr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        rx_ready  <= 1'b1;
                        state     <= S_CHK;
`else
                        load_done <= 1'b1;
                        state     <= S_DONE;
`endif
                    end else begin
                        imem_waddr <= imem_waddr + 1'b1;
                        byte_idx   <= '0;
                        rx_ready   <= 1'b1;
                        state      <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if (rx_data != csum)
                            load_err <= 1'b1;
                        rx_ready  <= 1'b0;
                        load_done <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load sessions driven through the byte
// handshake, expected memory writes kept in a scoreboard queue and matched
// against imem_we as it fires; plus a hand-written mid-session reset sequence.
module tb_imem_loader;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0]         n;
        logic [15:0][31:0]  words;
        logic               bp;          // random gaps between bytes
        logic               bad_ck;      // corrupt trailing checksum
        logic               stray_data;  // pulse start during DATA
        logic               stray_done;  // pulse start during DONE
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] tb_mem[DEPTH];
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write monitor: every imem_we must match the head of the scoreboard.
    always @(negedge CLOCK_50) begin
        if (RESET_N === 1'b1 && imem_we === 1'b1) begin
            tb_mem[imem_waddr] = imem_wdata;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                         imem_waddr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_waddr), 64'(e.a));
                chk("wr_data", 64'(imem_wdata), 64'(e.d));
                chk("rdy_in_write", 64'(rx_ready), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bp);
        int t;
        if (bp) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            cyc();
            t++;
        end
        if (!rx_ready) begin
            n_total++;
            $display("FAIL rx_ready_timeout: byte %0h never accepted", b);
            rx_valid = 1'b0;
            return;
        end
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({rx_ready, imem_we, imem_waddr, cpu_hold, load_done, load_err}), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    endtask

    task automatic run_session(input vec_t v);
        logic [7:0] ck;
        logic [7:0] b;
        int         nw;
        int         t;
        logic       exp_err;
        nw      = (v.n == 8'd0 || int'(v.n) > DEPTH) ? 0 : int'(v.n);
        exp_err = (nw == 0);
        ck      = v.n;
        // start together with a valid byte: nothing may be consumed in IDLE
        start    = 1'b1;
        rx_data  = v.n;
        rx_valid = 1'b1;
        cyc();
        start = 1'b0;
        chk("hold_after_start", 64'(cpu_hold), 64'd1);
        chk("err_cleared", 64'(load_err), 64'd0);
        send_byte(v.n, v.bp);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back('{a: ADDR_W'(i), d: v.words[i]});
            for (int j = 0; j < 4; j++) begin
                b  = v.words[i][8*j +: 8];
                ck = ck ^ b;
                send_byte(b, v.bp);
                if (v.stray_data && i == 0 && j == 1) begin
                    start = 1'b1;
                    cyc();
                    start = 1'b0;
                    chk("stray_hold", 64'(cpu_hold), 64'd1);
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (nw != 0) begin
            send_byte(v.bad_ck ? (ck ^ 8'hFF) : ck, v.bp);
            exp_err = v.bad_ck;
        end
`endif
        t = 0;
        while (!load_done && t < 20) begin
            cyc();
            t++;
        end
        chk("done_pulse", 64'(load_done), 64'd1);
        chk("hold_in_done", 64'(cpu_hold), 64'd1);
        chk("load_err", 64'(load_err), 64'(exp_err));
        if (v.stray_done) start = 1'b1;
        cyc();
        start = 1'b0;
        chk("done_low", 64'(load_done), 64'd0);
        chk("hold_low", 64'(cpu_hold), 64'd0);
        chk("err_sticky", 64'(load_err), 64'(exp_err));
        chk("writes_all_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        cyc();
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        for (int i = 0; i < 7; i++) tbl[i] = '0;
        tbl[0].n = 8'd2;  tbl[0].words[0] = 32'hE3A00004; tbl[0].words[1] = 32'hE0821001;
        tbl[1] = tbl[0];  tbl[1].bp = 1'b1;
        tbl[2].n = 8'd0;
        tbl[3].n = 8'h11; tbl[3].stray_done = 1'b1;
        tbl[4].n = 8'd1;  tbl[4].words[0] = 32'h12345678;
        tbl[5] = tbl[4];  tbl[5].bad_ck = 1'b1;
        tbl[6].n = 8'd16; tbl[6].bp = 1'b1; tbl[6].stray_data = 1'b1;
        for (int i = 0; i < 16; i++) tbl[6].words[i] = $urandom;

        RESET_N  = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #25;
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        cyc();
        // idle with valid and no start: still nothing ready
        rx_valid = 1'b1;
        cyc();
        chk("idle_not_ready", 64'({rx_ready, cpu_hold}), 64'd0);
        rx_valid = 1'b0;

        for (int k = 0; k < 7; k++) run_session(tbl[k]);

        // Mid-session reset after 6 data bytes of an N=2 load
        rv = tbl[0];
        rv.words[0] = 32'hCAFEF00D;
        rv.words[1] = 32'h0BADBEEF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        send_byte(8'd2, 1'b0);
        exp_q.push_back('{a: '0, d: rv.words[0]});
        for (int j = 0; j < 6; j++)
            send_byte(rv.words[j / 4][8*(j % 4) +: 8], 1'b0);
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #4;
        RESET_N = 1'b1;
        cyc();
        cyc();
        chk("midreset_no_done", 64'(load_done), 64'd0);
        chk("midreset_q", 64'(exp_q.size()), 64'd0);
        chk("midreset_word0", 64'(tb_mem[0]), 64'hCAFEF00D);
        exp_q.delete();
        run_session(tbl[0]);
        chk("reload_word1", 64'(tb_mem[1]), 64'hE0821001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side counterpart to the instruction memory. It receives a byte stream over a valid/ready handshake (host link, UART receiver or testbench), packs bytes little-endian into 32-bit instruction words, and drives the instruction memory write port. It holds the processor in `cpu_hold` while a load session is active, so fetch never sees a half-written program.

## Interface
- `DEPTH`, default 16: instruction memory depth in words; maximum legal word count.
- `ADDR_W`, default 4: width of the write address; `2**ADDR_W >= DEPTH`.

- `CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load session; ignored unless in IDLE.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction memory write enable, one cycle per word.
- `imem_waddr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  high while a session is active (any state other than IDLE).
- `load_done`  out  1  one-cycle pulse at the end of a session.
- `load_err`  out  1  sticky error flag; cleared on the next accepted `start`.

## Operation
- Stream format: byte 0 = word count N, then N×4 data bytes. The first byte of each word goes to `[7:0]` and the fourth to `[31:24]`. Words are written to addresses 0..N-1.
- FSM states:
  - IDLE: `rx_ready`=0. `start` → LEN, clears `load_err`, resets the word address and the byte index.
  - LEN: `rx_ready`=1. On transfer, latch N.
    - N==0 or N>DEPTH → set `load_err`, go to DONE.
    - Otherwise → DATA.
  - DATA: `rx_ready`=1. Each transfer shifts the byte into the word register at byte index 0..3. After the 4th byte → WRITE.
  - WRITE: `rx_ready`=0. `imem_we`=1 for exactly this cycle, with the current address and word.
    - If this was word N-1 → CHK (when enabled) or DONE.
    - Otherwise increment the address, reset the byte index → DATA.
  - CHK (only when compiled in): `rx_ready`=1. On transfer, compare the byte to the running checksum; on mismatch set `load_err`. → DONE.
  - DONE: `load_done`=1 for one cycle → IDLE.
- `rx_valid` without `rx_ready` is held off; the byte is neither consumed nor dropped.
- `imem_waddr` and `imem_wdata` are registered and stable during WRITE. `imem_we` is 0 in every state other than WRITE.

## Timing
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0; FSM in IDLE.
- `cpu_hold` rises the cycle after `start` is sampled in IDLE. It falls in the cycle following DONE, i.e. it is still high while `load_done` is high.
- Latency: the write occurs the cycle after the 4th byte transfer. Minimum session length is 1 + 5N cycles (+1 with checksum) after `start`, plus the DONE cycle.
- `start` asserted in the same cycle as `rx_valid` in IDLE: no byte is consumed, because `rx_ready`=0.
- `start` asserted outside IDLE: ignored, with no effect on state or flags.
- `RESET_N` low mid-session: the FSM immediately returns to IDLE and all outputs take their reset values. Words already written remain in memory. `load_done` does not pulse.
- The address never wraps: N≤DEPTH is enforced in LEN.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running XOR covers the count byte and every data byte.
  - One trailing checksum byte is accepted in CHK.
  - Mismatch sets `load_err`; words are still written and `load_done` still pulses.
- Not defined: no CHK state, no checksum logic; WRITE of the last word goes directly to DONE.

## Test plan
- Basic load: N=2, bytes 0x02, 0x04,0x00,0xA0,0xE3, 0x01,0x10,0x82,0xE0 → write 0xE3A00004 at addr 0, then 0xE0821001 at addr 1. One `load_done` pulse, `load_err`=0, `cpu_hold` high throughout.
- Backpressure: `rx_valid` toggling randomly and held during WRITE → identical memory contents. `rx_ready`=0 in the WRITE cycles; no byte lost or duplicated.
- Length error: count byte 0x00, and separately 0x11 with DEPTH=16 → `load_err`=1, no `imem_we`, `load_done` pulses, back to IDLE.
- Checksum (macro defined): stream for N=1 word 0x12345678 with trailing 0x09 → `load_err`=0. With trailing 0x00 → `load_err`=1, word still written.
- Reset mid-session: assert `RESET_N`=0 after 6 data bytes of N=2 → all outputs 0, FSM in IDLE. Word 0 is present in memory. A new `start` then loads correctly.
- Stray `start`: pulse `start` during DATA → no effect, and `load_err` is not cleared.
